// File: rtl/complex_div.sv
`default_nettype none
// ============================================================================
// Module   : complex_div
// Purpose  : Sequential complex divider z = a * conj(b) / |b|^2 using one
//            shared 8x8 signed multiplier and one restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module complex_div #(
  parameter int FRAC_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] a_real,
  input  logic signed [7:0] a_imag,
  input  logic signed [7:0] b_real,
  input  logic signed [7:0] b_imag,
  output logic              out_valid,
  output logic [15:0]       z_real,
  output logic [15:0]       z_imag,
  output logic              div_by_zero,
  output logic              overflow
);

  localparam int Q = 16 + FRAC_BITS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL    = 3'd1,
    S_COMB   = 3'd2,
    S_DIV_RE = 3'd3,
    S_DIV_IM = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t r_state, w_state_nxt;
  logic   w_in_ready;

  logic [4:0]        r_cnt;
  logic signed [7:0] r_ar, r_ai, r_br, r_bi;
  logic signed [15:0] r_p0, r_p1, r_p2, r_p3, r_p4, r_p5;
  logic [15:0]       r_den, r_mag_im, r_rem;
  logic              r_neg_re, r_neg_im;
  logic [Q-1:0]      r_quo, r_qre;
  logic              r_out_valid, r_dbz, r_ovf;
  logic [15:0]       r_z_re, r_z_im;

  logic signed [7:0]  w_ma, w_mb;
  logic signed [15:0] w_prod;
  logic [16:0]        w_num_re, w_num_im, w_trial;
  logic [15:0]        w_abs_re, w_abs_im, w_den, w_rem_nxt;
  logic               w_ge;
  logic [Q-1:0]       w_quo_nxt;
  logic [16:0]        w_sat_re, w_sat_im;

  // Sign/saturate a magnitude quotient; bit 16 of the result flags overflow.
  function automatic logic [16:0] f_sat(input logic neg, input logic [Q-1:0] mag);
    logic [15:0] m;
    m = mag[15:0];
    if (neg) begin
      if (mag > Q'(32768)) return {1'b1, 16'h8000};
      return {1'b0, 16'(~m + 16'd1)};
    end
    if (mag > Q'(32767)) return {1'b1, 16'h7FFF};
    return {1'b0, m};
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state sequencing and handshake ready.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_MUL;
      end
      S_MUL:    if (r_cnt == 5'd5) w_state_nxt = S_COMB;
      S_COMB:   w_state_nxt = S_DIV_RE;
      S_DIV_RE: if (r_cnt == 5'(Q - 1)) w_state_nxt = S_DIV_IM;
      S_DIV_IM: if (r_cnt == 5'(Q - 1)) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Shared multiplier operand selection, one product per MUL cycle.
  always_comb begin
    w_ma = r_ar;
    w_mb = r_br;
    case (r_cnt[2:0])
      3'd1:    begin w_ma = r_ai; w_mb = r_bi; end
      3'd2:    begin w_ma = r_ai; w_mb = r_br; end
      3'd3:    begin w_ma = r_ar; w_mb = r_bi; end
      3'd4:    begin w_ma = r_br; w_mb = r_br; end
      3'd5:    begin w_ma = r_bi; w_mb = r_bi; end
      default: begin w_ma = r_ar; w_mb = r_br; end
    endcase
  end

  // Operands are sign-extended so the 16-bit product is exact.
  assign w_prod   = {{8{w_ma[7]}}, w_ma} * {{8{w_mb[7]}}, w_mb};
  assign w_num_re = {r_p0[15], r_p0} + {r_p1[15], r_p1};
  assign w_num_im = {r_p2[15], r_p2} - {r_p3[15], r_p3};
  assign w_abs_re = 16'(w_num_re[16] ? (17'd0 - w_num_re) : w_num_re);
  assign w_abs_im = 16'(w_num_im[16] ? (17'd0 - w_num_im) : w_num_im);
  assign w_den    = $unsigned(r_p4) + $unsigned(r_p5);

  // One restoring-division step: shift in dividend MSB, subtract if it fits.
  assign w_trial   = {r_rem, r_quo[Q-1]};
  assign w_ge      = (w_trial >= {1'b0, r_den});
  assign w_rem_nxt = 16'(w_ge ? (w_trial - {1'b0, r_den}) : w_trial);
  assign w_quo_nxt = {r_quo[Q-2:0], w_ge};

  assign w_sat_re = f_sat(r_neg_re, r_qre);
  assign w_sat_im = f_sat(r_neg_im, r_quo);

  // Datapath: capture, multiply, combine, divide, and publish results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_ar <= '0; r_ai <= '0; r_br <= '0; r_bi <= '0;
      r_p0 <= '0; r_p1 <= '0; r_p2 <= '0; r_p3 <= '0; r_p4 <= '0; r_p5 <= '0;
      r_den <= '0; r_mag_im <= '0; r_rem <= '0;
      r_neg_re <= 1'b0; r_neg_im <= 1'b0;
      r_quo <= '0; r_qre <= '0;
      r_out_valid <= 1'b0; r_dbz <= 1'b0; r_ovf <= 1'b0;
      r_z_re <= '0; r_z_im <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (in_valid) begin
            r_ar <= a_real; r_ai <= a_imag; r_br <= b_real; r_bi <= b_imag;
          end
        end
        S_MUL: begin
          case (r_cnt[2:0])
            3'd0:    r_p0 <= w_prod;
            3'd1:    r_p1 <= w_prod;
            3'd2:    r_p2 <= w_prod;
            3'd3:    r_p3 <= w_prod;
            3'd4:    r_p4 <= w_prod;
            default: r_p5 <= w_prod;
          endcase
          r_cnt <= (r_cnt == 5'd5) ? 5'd0 : r_cnt + 5'd1;
        end
        S_COMB: begin
          r_den    <= w_den;
          r_neg_re <= w_num_re[16];
          r_neg_im <= w_num_im[16];
          r_mag_im <= w_abs_im;
          r_quo    <= Q'(w_abs_re) << FRAC_BITS;
          r_rem    <= '0;
          r_cnt    <= '0;
        end
        S_DIV_RE: begin
          if (r_cnt == 5'(Q - 1)) begin
            // Real quotient complete; reload divider with imaginary magnitude.
            r_qre <= w_quo_nxt;
            r_quo <= Q'(r_mag_im) << FRAC_BITS;
            r_rem <= '0;
            r_cnt <= '0;
          end else begin
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_DIV_IM: begin
          r_quo <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= (r_cnt == 5'(Q - 1)) ? 5'd0 : r_cnt + 5'd1;
        end
        S_DONE: begin
          r_out_valid <= 1'b1;
          if (r_den == 16'd0) begin
            r_z_re <= '0;
            r_z_im <= '0;
            r_dbz  <= 1'b1;
            r_ovf  <= 1'b0;
          end else begin
            r_z_re <= w_sat_re[15:0];
            r_z_im <= w_sat_im[15:0];
            r_dbz  <= 1'b0;
            r_ovf  <= w_sat_re[16] | w_sat_im[16];
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign z_real      = r_z_re;
  assign z_imag      = r_z_im;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_complex_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_complex_div
// Purpose  : Directed self-checking bench for complex_div (FRAC_BITS = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_complex_div;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] a_real, a_imag, b_real, b_imag;
  logic              out_valid;
  logic [15:0]       z_real, z_imag;
  logic              div_by_zero, overflow;

  int n_checks;
  int n_errors;

  complex_div #(.FRAC_BITS(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .out_valid(out_valid), .z_real(z_real), .z_imag(z_imag),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int ar, input int ai, input int br, input int bi);
    a_real = 8'(ar); a_imag = 8'(ai); b_real = 8'(br); b_imag = 8'(bi);
  endtask

  // Waits for out_valid after an accepting edge; returns edges counted.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) check("busy_ready", int'(in_ready), 0);
      if (out_valid) break;
    end
    if (!out_valid) check("timeout", 0, 1);
  endtask

  task automatic check_result(input string tag, input int lat, input int zr, input int zi,
                              input int dbz, input int ovf);
    check({tag, "_lat"}, lat, 56);
    check({tag, "_zre"}, int'($signed(z_real)), zr);
    check({tag, "_zim"}, int'($signed(z_imag)), zi);
    check({tag, "_dbz"}, int'(div_by_zero), dbz);
    check({tag, "_ovf"}, int'(overflow), ovf);
    check({tag, "_rdy"}, int'(in_ready), 1);
  endtask

  task automatic run_op(input string tag, input int ar, input int ai, input int br, input int bi,
                        input int zr, input int zi, input int dbz, input int ovf);
    int lat;
    @(negedge clk);
    check({tag, "_idle"}, int'(in_ready), 1);
    set_ops(ar, ai, br, bi);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    set_ops(0, 0, 0, 0);
    wait_done(lat);
    check_result(tag, lat, zr, zi, dbz, ovf);
    @(posedge clk);
    #1;
    check({tag, "_strobe"}, int'(out_valid), 0);
    check({tag, "_hold"}, int'($signed(z_real)), zr);
  endtask

  initial begin
    int lat;
    int seen;
    n_checks = 0;
    n_errors = 0;
    in_valid = 1'b0;
    set_ops(0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", int'(in_ready), 1);
    check("rst_valid", int'(out_valid), 0);
    check("rst_zre", int'(z_real), 0);
    check("rst_zim", int'(z_imag), 0);
    check("rst_flags", int'({div_by_zero, overflow}), 0);

    run_op("unit_re", 64, 0, 64, 0, 256, 0, 0, 0);
    run_op("unit_im", 0, 64, 0, 64, 256, 0, 0, 0);

    // Reset while the real-part division is in progress.
    @(negedge clk);
    set_ops(10, 20, 3, 4);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_zre", int'(z_real), 0);
    check("abort_zim", int'(z_imag), 0);
    check("abort_ready", int'(in_ready), 1);
    check("abort_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_valid", seen, 0);

    run_op("pos", 10, 20, 3, 4, 1126, 204, 0, 0);
    run_op("neg", -10, -20, 3, 4, -1126, -204, 0, 0);
    run_op("sat_pos", -128, 0, -1, 0, 32767, 0, 0, 1);
    run_op("sat_neg", -128, 0, 1, 0, -32768, 0, 0, 0);
    run_op("dbz", 5, 5, 0, 0, 0, 0, 1, 0);

    // Back-to-back with in_valid held high and operands changing while busy.
    @(negedge clk);
    set_ops(10, 20, 3, 4);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    set_ops(64, 0, 64, 0);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 30) set_ops(100, -50, 7, -2);
      if (out_valid) break;
    end
    if (!out_valid) check("b2b_timeout", 0, 1);
    check_result("b2b1", lat, 1126, 204, 0, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    set_ops(0, 0, 0, 0);
    check("b2b_taken", int'(in_ready), 0);
    wait_done(lat);
    check_result("b2b2", lat, 3864, -724, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/complex_div.md
Name: complex_div

Overview:
- Sequential complex divider: z = a / b = (a · conj(b)) / |b|².
- Inputs are signed 8-bit complex operands; outputs are signed fixed-point quotient components.
- Companion to the shared-multiplier complex multiplier in the same arithmetic datapath. Uses one shared 8x8 multiplier and one iterative restoring divider.
- Valid/ready input handshake, single-cycle output strobe.

Parameters:
- FRAC_BITS, 8, number of fractional bits in the quotient (output format Q(15-FRAC_BITS).FRAC_BITS); legal range 0..8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block idle, can accept operands
- a_real  input  8  signed dividend real part
- a_imag  input  8  signed dividend imaginary part
- b_real  input  8  signed divisor real part
- b_imag  input  8  signed divisor imaginary part
- out_valid  output  1  one-cycle strobe, results valid
- z_real  output  16  signed quotient real part, FRAC_BITS fractional bits
- z_imag  output  16  signed quotient imaginary part, FRAC_BITS fractional bits
- div_by_zero  output  1  set with out_valid when b = 0
- overflow  output  1  set with out_valid when either component saturated

Behaviour:
- Reset (async, active-high): state IDLE, in_ready=1, out_valid=0, z_real=z_imag=0, div_by_zero=overflow=0, all internal registers cleared. Reset mid-operation aborts the operation; no out_valid is produced for it.
- Accept: in_valid && in_ready at a rising edge registers all four operands. in_ready drops the next cycle and stays low until DONE completes. in_valid while busy is ignored; operands are not captured.
- Fixed latency Q = 16+FRAC_BITS. out_valid is high for exactly one cycle, starting 8+2Q edges after the accepting edge (56 at default). in_ready returns high in the same cycle as out_valid. A new accept is allowed on that cycle's edge.
- States:
  - IDLE: wait for accept.
  - MUL (6 cycles): one product per cycle through the single shared signed 8x8 multiplier, in order ar·br, ai·bi, ai·br, ar·bi, br·br, bi·bi, into 16-bit registers.
  - COMBINE (1 cycle): num_re = ar·br + ai·bi; num_im = ai·br − ar·bi (both 17-bit signed); den = br² + bi² (16-bit unsigned, max 32768).
  - DIV_RE (Q cycles), then DIV_IM (Q cycles): restoring division of |num|·2^FRAC_BITS (Q-bit unsigned) by den, one quotient bit per cycle, MSB first.
  - DONE (1 cycle): apply sign, saturate, drive outputs, pulse out_valid, then go to IDLE.
- Sign: negate the magnitude quotient when num is negative (den ≥ 0). Truncation is toward zero.
- Saturation: positive result > 32767 gives 32767; negative magnitude > 32768 gives −32768. Either case sets overflow.
- den = 0: the divider is bypassed in effect. z_real=z_imag=0, div_by_zero=1, overflow=0. Latency is unchanged.
- z_real, z_imag, div_by_zero and overflow hold their values until the next DONE or reset. Flags update only in DONE.

Test Plan:
- Reset asserted mid-DIV_RE of any operation -> outputs all 0 immediately, in_ready=1, no out_valid follows; a following op completes normally.
- a=(64,0), b=(64,0) -> z=(256,0), flags 0, out_valid exactly 56 edges after accept; a=(0,64), b=(0,64) -> z=(256,0).
- a=(10,20), b=(3,4) -> z=(1126,204); a=(−10,−20), b=(3,4) -> z=(−1126,−204) (truncation toward zero).
- a=(−128,0), b=(−1,0) -> z_real=32767, z_imag=0, overflow=1; a=(−128,0), b=(1,0) -> z_real=−32768, overflow=0.
- a=(5,5), b=(0,0) -> z=(0,0), div_by_zero=1, overflow=0, latency 56.
- Back-to-back: hold in_valid high with changing operands -> second op accepted only on the out_valid cycle of the first; operands presented while busy are ignored; results match the captured operands.
